// File: rtl/modport_dma.sv
// Single-channel DMA register block and transfer engine.
// An APB slave (zero wait states) holds the channel configuration. The engine
// counts the programmed byte length down in BEAT_BYTES steps, one per clk,
// and raises DONE/INT when the count is exhausted. No memory-side bus.
module modport_dma #(
  parameter int NUM_CH     = 1,
  parameter int BEAT_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pclken,
  input  logic              psel,
  input  logic              penable,
  input  logic [12:0]       paddr,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic              pready,
  input  logic              scan_en,
  output logic [NUM_CH-1:0] INT,
  output logic              idle
);

  localparam logic [15:0] BEAT = 16'(BEAT_BYTES);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] size;
  logic [15:0] remain;
  logic        int_en;
  logic        done;
  logic        err;

  logic        busy;
  logic        acc;
  logic        wr_ok;
  logic        start;
  logic        mapped;
  logic        sel_src, sel_dst, sel_size, sel_ctrl, sel_status, sel_remain;
  logic [31:0] rdata;

  assign busy = (state == RUN);
  assign acc  = pclken & psel & penable;

  assign sel_src    = (paddr == 13'h000);
  assign sel_dst    = (paddr == 13'h004);
  assign sel_size   = (paddr == 13'h008);
  assign sel_ctrl   = (paddr == 13'h00C);
  assign sel_status = (paddr == 13'h010);
  assign sel_remain = (paddr == 13'h014);
  assign mapped     = sel_src | sel_dst | sel_size | sel_ctrl | sel_status | sel_remain;

  // Configuration registers are frozen while the channel runs; REMAIN is
  // read-only. STATUS stays writable so software can always clear flags.
  assign pslverr = acc & (~mapped
                          | (pwrite & sel_remain)
                          | (pwrite & busy & (sel_src | sel_dst | sel_size | sel_ctrl)));
  assign pready  = acc;
  assign wr_ok   = acc & pwrite & ~pslverr;
  assign start   = wr_ok & sel_ctrl & pwdata[0];

  // Read mux: START always reads 0, unused upper bits read 0.
  always_comb begin
    rdata = 32'h0;
    unique case (1'b1)
      sel_src:    rdata = src;
      sel_dst:    rdata = dst;
      sel_size:   rdata = {16'h0, size};
      sel_ctrl:   rdata = {30'h0, int_en, 1'b0};
      sel_status: rdata = {29'h0, err, done, busy};
      sel_remain: rdata = {16'h0, remain};
      default:    rdata = 32'h0;
    endcase
  end

  assign prdata = (acc & ~pwrite & mapped) ? rdata : 32'h0;

  // Engine state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Engine next-state: start only with a nonzero length; finish on last beat.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && size != 16'h0) state_next = RUN;
      RUN:     if (remain <= BEAT)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register file, status flags and beat counter. The engine's DONE set is
  // applied after the W1C clear so a same-edge set wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src    <= 32'h0;
      dst    <= 32'h0;
      size   <= 16'h0;
      remain <= 16'h0;
      int_en <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (wr_ok && sel_src)  src    <= pwdata;
      if (wr_ok && sel_dst)  dst    <= pwdata;
      if (wr_ok && sel_size) size   <= pwdata[15:0];
      if (wr_ok && sel_ctrl) int_en <= pwdata[1];
      if (wr_ok && sel_status) begin
        if (pwdata[1]) done <= 1'b0;
        if (pwdata[2]) err  <= 1'b0;
      end
      if (start) begin
        if (size != 16'h0) begin
          remain <= size;
          done   <= 1'b0;
          err    <= 1'b0;
        end else begin
          err    <= 1'b1;
        end
      end
      if (state == RUN) begin
        if (remain > BEAT) begin
          remain <= remain - BEAT;
        end else begin
          remain <= 16'h0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign idle = ~busy;
  assign INT  = {NUM_CH{int_en & (done | err) & ~scan_en}};

endmodule

// File: tb/tb_modport_dma.sv
// Directed bench for modport_dma: APB register access, engine timing,
// error responses, interrupt gating and reset abort.
module tb_modport_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        pclken;
  logic        psel;
  logic        penable;
  logic [12:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pready;
  logic        scan_en;
  logic [0:0]  INT;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;

  modport_dma #(.NUM_CH(1), .BEAT_BYTES(4)) dut (
    .clk(clk), .reset(reset), .pclken(pclken), .psel(psel), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pslverr(pslverr), .pready(pready), .scan_en(scan_en), .INT(INT), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle APB write; returns pslverr seen during the access.
  task automatic apb_wr(input logic [12:0] a, input logic [31:0] d, input logic en,
                        output logic err);
    @(negedge clk);
    pclken = en; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
    #1 err = pslverr;
    @(posedge clk);
    #1 pclken = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [12:0] a, output logic [31:0] d, output logic err);
    @(negedge clk);
    pclken = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1 d = prdata; err = pslverr;
    @(posedge clk);
    #1 pclken = 1'b0; psel = 1'b0; penable = 1'b0;
  endtask

  // Counts clocks with idle low, starting right after the start edge.
  task automatic count_busy(output int n);
    n = 0;
    while (!idle && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;
    logic [31:0] exp_reset [6];
    reset = 1'b0; pclken = 1'b0; psel = 1'b0; penable = 1'b0;
    paddr = '0; pwrite = 1'b0; pwdata = '0; scan_en = 1'b0;
    for (int i = 0; i < 6; i++) exp_reset[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    #1;
    check("idle_rst", {31'h0, idle}, 32'h1);
    check("int_rst", {31'h0, INT}, 32'h0);
    check("pready_noacc", {31'h0, pready}, 32'h0);
    check("prdata_noacc", prdata, 32'h0);
    for (int i = 0; i < 6; i++) begin
      apb_rd(13'(i * 4), d, e);
      check($sformatf("rst_rd_%0h", i * 4), d, exp_reset[i]);
      check($sformatf("rst_err_%0h", i * 4), {31'h0, e}, 32'h0);
    end

    // Register write/read-back
    apb_wr(13'h000, 32'hA5A5_0000, 1'b1, e);
    check("wr_src_err", {31'h0, e}, 32'h0);
    apb_wr(13'h004, 32'h1234_5678, 1'b1, e);
    apb_wr(13'h008, 32'hFFFF_0010, 1'b1, e);
    apb_rd(13'h000, d, e); check("rd_src", d, 32'hA5A5_0000);
    apb_rd(13'h004, d, e); check("rd_dst", d, 32'h1234_5678);
    apb_rd(13'h008, d, e); check("rd_size_upper0", d, 32'h0000_0010);
    apb_rd(13'h020, d, e);
    check("rd_unmapped_data", d, 32'h0);
    check("rd_unmapped_err", {31'h0, e}, 32'h1);
    apb_wr(13'h014, 32'h55, 1'b1, e);
    check("wr_remain_err", {31'h0, e}, 32'h1);
    apb_rd(13'h014, d, e); check("remain_unchanged", d, 32'h0);

    // SIZE=0x10 transfer: 4 busy clocks
    apb_wr(13'h00C, 32'h3, 1'b1, e);
    count_busy(n);
    check("busy_clocks_16", n, 4);
    apb_rd(13'h010, d, e); check("status_done", d, 32'h2);
    apb_rd(13'h014, d, e); check("remain_zero", d, 32'h0);
    apb_rd(13'h00C, d, e); check("ctrl_rd", d, 32'h2);
    check("int_done", {31'h0, INT}, 32'h1);
    apb_wr(13'h010, 32'h2, 1'b1, e);
    #1 check("int_cleared", {31'h0, INT}, 32'h0);
    apb_rd(13'h010, d, e); check("status_cleared", d, 32'h0);

    // SIZE=9: 3 busy clocks
    apb_wr(13'h008, 32'h9, 1'b1, e);
    apb_wr(13'h00C, 32'h3, 1'b1, e);
    count_busy(n);
    check("busy_clocks_9", n, 3);

    // Mid-run SIZE write is rejected
    apb_wr(13'h00C, 32'h3, 1'b1, e);
    apb_wr(13'h008, 32'h55, 1'b1, e);
    check("midrun_size_err", {31'h0, e}, 32'h1);
    count_busy(n);
    apb_rd(13'h008, d, e); check("size_kept", d, 32'h9);

    // START with SIZE=0 -> ERR
    apb_wr(13'h010, 32'h6, 1'b1, e);
    apb_wr(13'h008, 32'h0, 1'b1, e);
    apb_wr(13'h00C, 32'h3, 1'b1, e);
    check("zero_idle", {31'h0, idle}, 32'h1);
    apb_rd(13'h010, d, e); check("zero_status", d, 32'h4);
    check("zero_int", {31'h0, INT}, 32'h1);
    scan_en = 1'b1;
    #1 check("scan_int", {31'h0, INT}, 32'h0);
    scan_en = 1'b0;

    // Reset aborts a running transfer
    apb_wr(13'h008, 32'h40, 1'b1, e);
    apb_wr(13'h00C, 32'h3, 1'b1, e);
    repeat (5) @(posedge clk);
    apb_rd(13'h014, d, e); check("remain_midrun", d, 32'h2C);
    apb_rd(13'h010, d, e); check("status_busy", d, 32'h1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    check("abort_idle", {31'h0, idle}, 32'h1);
    check("abort_int", {31'h0, INT}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      apb_rd(13'(i * 4), d, e);
      check($sformatf("abort_rd_%0h", i * 4), d, exp_reset[i]);
    end

    // Write ignored with pclken=0
    apb_wr(13'h000, 32'hDEAD_BEEF, 1'b0, e);
    check("noen_err", {31'h0, e}, 32'h0);
    apb_rd(13'h000, d, e); check("noen_src", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
